// File: rtl/fdiv_pkg.sv
// Shared types and default widths for the FP divider mantissa iteration stage.
package fdiv_pkg;

    // Default widths for single precision (hidden bit included, one exponent guard bit).
    localparam int unsigned MantW = 24;
    localparam int unsigned ExpW  = 9;
    localparam int unsigned CntW  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StDiv,
        StDone
    } fdiv_state_e;

    // Result record handed to the rounding stage (default widths).
    typedef struct packed {
        logic             sign;
        logic [ExpW-1:0]  exp;
        logic [MantW-1:0] quot;
        logic             guard;
        logic             sticky;
        logic             dz;
    } fdiv_result_t;

endpackage

// File: rtl/fdiv_mant_iter_if.sv
// Operand/result handshake bundle between div_p1, the mantissa iterator and rounding.
interface fdiv_mant_iter_if #(
    parameter int unsigned MW = 24,
    parameter int unsigned EW = 9
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          sign_in;
    logic [EW-1:0] exp_in;
    logic [MW-1:0] mant_a_in;
    logic [MW-1:0] mant_b_in;
    logic          out_valid;
    logic          out_ready;
    logic          sign_out;
    logic [EW-1:0] exp_out;
    logic [MW-1:0] quot_out;
    logic          guard_out;
    logic          sticky_out;
    logic          dz_out;

    // Driver of operands and consumer of results.
    modport master (
        output flush, in_valid, sign_in, exp_in, mant_a_in, mant_b_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, quot_out, guard_out, sticky_out, dz_out
    );

    // The divider itself.
    modport slave (
        input  flush, in_valid, sign_in, exp_in, mant_a_in, mant_b_in, out_ready,
        output in_ready, out_valid, sign_out, exp_out, quot_out, guard_out, sticky_out, dz_out
    );
endinterface

// File: rtl/fdiv_restore_step.sv
// One combinational radix-2 restoring division iteration.
module fdiv_restore_step #(
    parameter int unsigned MW = 24
) (
    input  logic [MW:0]   rem,
    input  logic [MW-1:0] den,
    output logic [MW:0]   rem_sub,
    output logic [MW:0]   rem_nxt,
    output logic          qbit
);
    logic [MW:0] den_ext;
    logic [MW:0] diff;

    // Conditional subtract, then shift the partial remainder for the next bit.
    always_comb begin
        den_ext = {1'b0, den};
        diff    = rem - den_ext;
        qbit    = (rem >= den_ext);
        rem_sub = qbit ? diff : rem;
        // rem_sub < den, so the shift never drops a set bit.
        rem_nxt = rem_sub << 1;
    end

endmodule

// File: rtl/fdiv_mant_iter.sv
// FP divider stage 2: pre-normalise, iterate restoring division, hand off to rounding.
module fdiv_mant_iter
    import fdiv_pkg::*;
#(
    parameter int unsigned MW = MantW,
    parameter int unsigned EW = ExpW,
    parameter int unsigned CW = CntW
) (
    input  logic             clk,
    input  logic             rst_n,
    fdiv_mant_iter_if.slave  bus
);

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] quot;
        logic          guard;
        logic          sticky;
        logic          dz;
    } res_t;

    fdiv_state_e   state_q, state_d;
    logic          sign_q;
    logic [EW-1:0] exp_q;
    logic [MW-1:0] a_q;
    logic [MW-1:0] b_q;
    logic [MW:0]   rem_q;
    logic [MW:0]   quot_q;
    logic [CW-1:0] cnt_q;
    res_t          res_q;

    logic [MW:0]   rem_sub;
    logic [MW:0]   rem_nxt;
    logic          qbit;
    logic [MW:0]   quot_nxt;

    fdiv_restore_step #(
        .MW (MW)
    ) u_step (
        .rem     (rem_q),
        .den     (b_q),
        .rem_sub (rem_sub),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    assign quot_nxt = {quot_q[MW-1:0], qbit};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (bus.in_valid) state_d = StNorm;
                StNorm: state_d = (b_q == '0 || a_q == '0) ? StDone : StDiv;
                StDiv:  if (cnt_q == '0) state_d = StDone;
                StDone: if (bus.out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Handshake outputs and result presentation.
    always_comb begin
        bus.in_ready   = (state_q == StIdle);
        bus.out_valid  = (state_q == StDone);
        bus.sign_out   = res_q.sign;
        bus.exp_out    = res_q.exp;
        bus.quot_out   = res_q.quot;
        bus.guard_out  = res_q.guard;
        bus.sticky_out = res_q.sticky;
        bus.dz_out     = res_q.dz;
    end

    // Operand capture, pre-normalisation, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (!bus.flush) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.sign_in;
                        exp_q  <= bus.exp_in;
                        a_q    <= bus.mant_a_in;
                        b_q    <= bus.mant_b_in;
                    end
                end
                StNorm: begin
                    quot_q <= '0;
                    cnt_q  <= CW'(MW);
                    if (b_q == '0) begin
                        res_q <= '{sign: sign_q, exp: exp_q, quot: '0,
                                   guard: 1'b0, sticky: 1'b0, dz: 1'b1};
                    end else if (a_q == '0) begin
                        res_q <= '{sign: sign_q, exp: '0, quot: '0,
                                   guard: 1'b0, sticky: 1'b0, dz: 1'b0};
                    end else if (a_q < b_q) begin
                        // Doubling A keeps the quotient in [1,2); compensate in the exponent.
                        rem_q <= {a_q, 1'b0};
                        exp_q <= exp_q - EW'(1);
                    end else begin
                        rem_q <= {1'b0, a_q};
                    end
                end
                StDiv: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        res_q <= '{sign: sign_q, exp: exp_q, quot: quot_nxt[MW:1],
                                   guard: quot_nxt[0], sticky: (rem_sub != '0), dz: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_mant_iter.sv
// Directed bench for fdiv_mant_iter with hand-computed quotients.
module tb_fdiv_mant_iter;

    localparam int unsigned MW = 24;
    localparam int unsigned EW = 9;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fdiv_mant_iter_if #(.MW(MW), .EW(EW)) bus ();

    fdiv_mant_iter #(.MW(MW), .EW(EW), .CW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accepting edge; returns just after that edge.
    task automatic issue(input logic s, input logic [EW-1:0] e,
                         input logic [MW-1:0] a, input logic [MW-1:0] b);
        bus.in_valid  = 1'b1;
        bus.sign_in   = s;
        bus.exp_in    = e;
        bus.mant_a_in = a;
        bus.mant_b_in = b;
        step();
        bus.in_valid  = 1'b0;
    endtask

    // Edges counted including the accepting one, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_res(input string tag, input logic s, input logic [EW-1:0] e,
                             input logic [MW-1:0] q, input logic g, input logic st,
                             input logic dz);
        check({tag, ".valid"},  32'(bus.out_valid), 32'd1);
        check({tag, ".sign"},   32'(bus.sign_out), 32'(s));
        check({tag, ".exp"},    32'(bus.exp_out), 32'(e));
        check({tag, ".quot"},   32'(bus.quot_out), 32'(q));
        check({tag, ".guard"},  32'(bus.guard_out), 32'(g));
        check({tag, ".sticky"}, 32'(bus.sticky_out), 32'(st));
        check({tag, ".dz"},     32'(bus.dz_out), 32'(dz));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".idle_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [EW-1:0] e,
                          input logic [MW-1:0] a, input logic [MW-1:0] b, input int lat,
                          input logic rs, input logic [EW-1:0] re, input logic [MW-1:0] q,
                          input logic g, input logic st, input logic dz);
        int cyc;
        issue(s, e, a, b);
        wait_valid(cyc);
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check_res(tag, rs, re, q, g, st, dz);
        handshake(tag);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [MW-1:0] q_hold;
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.mant_a_in = '0;
        bus.mant_b_in = '0;
        bus.out_ready = 1'b0;

        #2;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.quot", 32'(bus.quot_out), 32'd0);
        check("rst.exp", 32'(bus.exp_out), 32'd0);
        check("rst.dz", 32'(bus.dz_out), 32'd0);
        #10 rst_n = 1'b1;
        step();

        // tag, sign, exp, a, b, latency, expected sign/exp/quot/guard/sticky/dz
        run_op("one_one",  1'b0, 9'd127, 24'h800000, 24'h800000, 27,
               1'b0, 9'd127, 24'h800000, 1'b0, 1'b0, 1'b0);
        run_op("one_1p5",  1'b0, 9'd127, 24'h800000, 24'hC00000, 27,
               1'b0, 9'd126, 24'hAAAAAA, 1'b1, 1'b1, 1'b0);
        run_op("1p5_one",  1'b1, 9'd130, 24'hC00000, 24'h800000, 27,
               1'b1, 9'd130, 24'hC00000, 1'b0, 1'b0, 1'b0);
        run_op("div_zero", 1'b0, 9'd127, 24'h900000, 24'h000000, 2,
               1'b0, 9'd127, 24'h000000, 1'b0, 1'b0, 1'b1);
        run_op("zero_num", 1'b1, 9'd127, 24'h000000, 24'h800000, 2,
               1'b1, 9'd0,   24'h000000, 1'b0, 1'b0, 1'b0);

        // Backpressure: hold result 5 cycles while a new request is waiting.
        issue(1'b0, 9'd127, 24'h800000, 24'hC00000);
        wait_valid(cyc);
        check("bp.latency", 32'(cyc), 32'd27);
        q_hold = bus.quot_out;
        bus.in_valid  = 1'b1;
        bus.mant_a_in = 24'h800000;
        bus.mant_b_in = 24'h800000;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.quot_out !== q_hold || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                seen++;
        end
        check("bp.stable_cycles_bad", 32'(seen), 32'd0);
        check_res("bp.held", 1'b0, 9'd126, 24'hAAAAAA, 1'b1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp.after_hs_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        wait_valid(cyc);
        check("bp.next_latency", 32'(cyc), 32'd27);
        check_res("bp.next", 1'b0, 9'd127, 24'h800000, 1'b0, 1'b0, 1'b0);
        handshake("bp.next");

        // Flush while in_valid in IDLE: nothing accepted.
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_idle.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("flush_idle.no_start", 32'(bus.in_ready), 32'd1);

        // Flush at DIV iteration 10.
        issue(1'b0, 9'd127, 24'h800000, 24'hC00000);
        for (int i = 0; i < 11; i++) step();
        check("flush.busy", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush.in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        check("flush.no_valid", 32'(seen), 32'd0);
        run_op("post_flush", 1'b1, 9'd130, 24'hC00000, 24'h800000, 27,
               1'b1, 9'd130, 24'hC00000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-DIV: outputs clear before any clock edge.
        issue(1'b0, 9'd127, 24'h800000, 24'hC00000);
        for (int i = 0; i < 12; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst.in_ready", 32'(bus.in_ready), 32'd1);
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.quot", 32'(bus.quot_out), 32'd0);
        check("arst.sign", 32'(bus.sign_out), 32'd0);
        check("arst.exp", 32'(bus.exp_out), 32'd0);
        #10 rst_n = 1'b1;
        step();
        run_op("post_rst", 1'b0, 9'd127, 24'h800000, 24'h800000, 27,
               1'b0, 9'd127, 24'h800000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fdiv_mant_iter.md
Name: fdiv_mant_iter

Overview:
- Parametrised successor to the FP divider's second pipeline stage; receives sign/exponent/mantissas from div_p1.
- Pre-normalises the numerator against the denominator so the quotient lands in [1,2).
- Runs an iterative radix-2 restoring mantissa division.
- Delivers quotient, guard and sticky bits to the rounding stage over a valid/ready handshake. One operation in flight.

Parameters:
MW, 24, mantissa width including hidden bit
EW, 9, exponent width (biased, one guard bit for under/overflow)
CW, 5, iteration counter width; must satisfy 2^CW > MW

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
flush  in  1  synchronous abort of any in-flight operation
in_valid  in  1  operand valid from div_p1
in_ready  out  1  block can accept operands
sign_in  in  1  result sign
exp_in  in  EW  exponent difference + bias
mant_a_in  in  MW  numerator mantissa
mant_b_in  in  MW  denominator mantissa
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sign_out  out  1  propagated sign
exp_out  out  EW  adjusted exponent
quot_out  out  MW  quotient mantissa, MSB = integer bit
guard_out  out  1  first quotient bit below LSB
sticky_out  out  1  OR of all lower bits (remainder != 0)
dz_out  out  1  divide-by-zero (mant_b_in == 0)

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE; counter, remainder and quotient registers are cleared.
  - All outputs go to 0 except in_ready, which is 1. A reset mid-operation discards the operation.
- States: IDLE, NORM, DIV, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - in_valid & in_ready: latch sign, exp, mant_a, mant_b, then go to NORM.
  - Otherwise stay in IDLE.
- NORM (1 cycle):
  - If mant_b == 0: quot = 0, guard = sticky = 0, dz = 1, exp passed unchanged; go to DONE.
  - Else if mant_a == 0: quot = 0, exp = 0, guard = sticky = 0; go to DONE.
  - Else if mant_a < mant_b: remainder = {mant_a, 0} (MW+1 bits), exp = exp - 1.
  - Else: remainder = {0, mant_a}.
  - In both non-zero cases, counter = MW and the block goes to DIV.
- DIV (MW+1 cycles, counter MW down to 0):
  - Each cycle: if R >= {0, B}, then qbit = 1 and R = R - B; else qbit = 0.
  - qbit is shifted into the MW+1-bit quotient register; R is shifted left 1.
  - When counter == 0: quot = Q[MW:1], guard = Q[0], sticky = (final R != 0); go to DONE.
- DONE:
  - Outputs are held stable while out_ready is low.
  - out_ready high: go to IDLE. There is no same-cycle re-accept, so throughput is one operation per MW+4 cycles minimum.
- Latency:
  - Normal operands: out_valid rises MW+3 rising edges after the accepting edge (27 for MW=24).
  - Zero or dz operands: out_valid rises 2 edges after the accepting edge.
- Exponent arithmetic is EW-bit modulo; no saturation. Overflow and underflow handling belong to the rounding stage.
- flush: any state goes to IDLE on the next edge; result discarded; out_valid drops. If flush and out_ready coincide, flush wins (no handshake counted). If flush and in_valid coincide in IDLE, nothing is accepted.
- in_valid while busy is ignored; the upstream holds its operands until in_ready.
- Quotient MSB is always 1 for non-zero, non-dz operands.

Decomposition:
- Package fdiv_pkg: state enum (IDLE/NORM/DIV/DONE), default MW/EW/CW constants, and an fdiv_result struct (sign, exp, quot, guard, sticky, dz) shared with the rounding stage.
- One sub-module, fdiv_restore_step: a combinational single iteration. It takes R and B and returns the next R and qbit.
- Top level holds the FSM, counter and registers.

Test Plan:
- 1.0/1.0: mant_a = 0x800000, mant_b = 0x800000, exp_in = 127 -> after 27 edges quot = 0x800000, exp = 127, guard = 0, sticky = 0, dz = 0.
- 1.0/1.5: mant_a = 0x800000, mant_b = 0xC00000, exp_in = 127 -> quot = 0xAAAAAA, exp = 126, guard = 1, sticky = 1.
- 1.5/1.0: mant_a = 0xC00000, mant_b = 0x800000, exp_in = 130, sign_in = 1 -> quot = 0xC00000, exp = 130, sign = 1, guard = 0, sticky = 0.
- Divide by zero: mant_b = 0, mant_a = 0x900000 -> out_valid after 2 edges, dz = 1, quot = 0. Second case: mant_a = 0, mant_b = 0x800000 -> exp = 0, dz = 0.
- Backpressure: complete 1.0/1.5 with out_ready held low 5 cycles -> outputs stable and in_ready = 0 throughout. A new in_valid is ignored until after the handshake.
- Abort:
  - Assert flush at DIV iteration 10 -> in_ready = 1 next cycle, no out_valid; the next operation completes correctly.
  - Repeat with rst_n pulsed low mid-DIV -> all outputs 0 asynchronously.
